// File: rtl/sm_mult_seq.sv
// rtl/sm_mult_seq.sv - sequential radix-2 shift-add sign-magnitude multiplier with valid/ready
// Optional early exit on an exhausted multiplier: define SM_MULT_EARLY_EXIT_EN.
module sm_mult_seq #(
    parameter int MAG_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAG_W:0]     a,
    input  logic [MAG_W:0]     b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*MAG_W:0]   prdct,
    output logic               busy
);

    localparam int CW = $clog2(MAG_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*MAG_W-1:0]   mcand;
    logic [2*MAG_W-1:0]   acc;
    logic [2*MAG_W-1:0]   acc_next;
    logic [MAG_W-1:0]     mplier;
    logic                 sign;
    logic [CW-1:0]        cnt;
    logic                 last_step;
    logic                 accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    // mcand is shifted left each step, so it always carries the weight of the current bit.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

`ifdef SM_MULT_EARLY_EXIT_EN
    assign last_step = (cnt == CW'(MAG_W - 1)) || ((mplier >> 1) == '0);
`else
    assign last_step = (cnt == CW'(MAG_W - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = in_valid ? CALC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sign   <= 1'b0;
            cnt    <= '0;
            prdct  <= '0;
        end else if (accept) begin
            mcand  <= {{MAG_W{1'b0}}, a[MAG_W-1:0]};
            mplier <= b[MAG_W-1:0];
            sign   <= a[MAG_W] ^ b[MAG_W];
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_step) begin
                // A zero magnitude never carries a sign, so -0 cannot be emitted.
                prdct <= {sign && (acc_next != '0), acc_next};
            end
        end
    end

endmodule

// File: tb/tb_sm_mult_seq.sv
// tb/tb_sm_mult_seq.sv - scoreboard bench for sm_mult_seq (MAG_W=8)
module tb_sm_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  a;
    logic [8:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] prdct;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic ov_prev = 1'b0;

    logic [16:0] exp_q[$];
    int          acc_q[$];
    int          lat_q[$];

    sm_mult_seq #(.MAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .prdct(prdct), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [8:0] x, input logic [8:0] y);
        logic [15:0] mag;
        mag = x[7:0] * y[7:0];
        return {(x[8] ^ y[8]) && (mag != 16'd0), mag};
    endfunction

    function automatic int lat_model(input logic [8:0] y);
`ifdef SM_MULT_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < 8; i++) if (y[i]) l = i + 1;
        return l;
`else
        return 8;
`endif
    endfunction

    // Monitor: latency on out_valid rise, value on each completed transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev && acc_q.size() > 0)
                check("latency", cyc - acc_q[0], lat_q[0]);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("prdct", prdct, exp_q.pop_front());
                    void'(acc_q.pop_front());
                    void'(lat_q.pop_front());
                end
            end
        end
        ov_prev <= out_valid;
    end

    // Called at posedge+2; returns at posedge+2 of the accepting edge.
    task automatic send(input logic [8:0] x, input logic [8:0] y);
        bit done;
        done = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(x, y));
                acc_q.push_back(cyc + 1);
                lat_q.push_back(lat_model(y));
                done = 1;
            end
            @(posedge clk);
            #2;
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) check(tag, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_prdct", prdct, 0);
        @(posedge clk);
        #2;

        // Mixed signs, fixed latency, single-cycle out_valid
        send(9'h005, 9'h103);
        check("busy_calc", busy, 1);
        wait_valid("t1_timeout");
        check("t1_value", prdct, 17'h1000F);
        @(negedge clk);
        check("t1_one_cycle", out_valid, 0);
        @(posedge clk);
        #2;

        send(9'h1FF, 9'h1FF);
        wait_valid("t2_timeout");
        check("t2_value", prdct, 17'h0FE01);
        @(posedge clk);
        #2;

        send(9'h100, 9'h007);
        wait_valid("t3a_timeout");
        check("t3a_value", prdct, 17'h00000);
        @(posedge clk);
        #2;
        send(9'h003, 9'h100);
        wait_valid("t3b_timeout");
        check("t3b_value", prdct, 17'h00000);
        @(posedge clk);
        #2;

        // Backpressure, then same-edge accept
        out_ready = 1'b0;
        send(9'h005, 9'h003);
        wait_valid("t4_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_prdct", prdct, 17'h0000F);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        send(9'h002, 9'h002);
        wait_valid("t4b_timeout");
        check("t4b_value", prdct, 17'h00004);
        @(posedge clk);
        #2;

        // Reset mid-CALC discards the in-flight op
        send(9'h0FF, 9'h0FF);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_prdct", prdct, 0);
        @(posedge clk);
        #2;
        send(9'h001, 9'h001);
        wait_valid("t5_timeout");
        check("t5_value", prdct, 17'h00001);
        @(posedge clk);
        #2;

        // Multiplier patterns that exercise early exit
        send(9'h0AA, 9'h001);
        wait_valid("t6a_timeout");
        check("t6a_value", prdct, 17'h000AA);
        @(posedge clk);
        #2;
        send(9'h0AA, 9'h000);
        wait_valid("t6b_timeout");
        @(posedge clk);
        #2;
        send(9'h0AA, 9'h080);
        wait_valid("t6c_timeout");
        @(posedge clk);
        #2;

        for (int i = 0; i < 12; i++) begin
            send(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
            repeat ($urandom_range(0, 10)) @(posedge clk);
            #2;
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
